// File: rtl/lms_coeff_bank.sv
// LMS coefficient bank: FFE tap delay line, coefficient registers with decimated adapter write-back,
// host load/freeze, and an optional readback port enabled by defining LMS_COEFF_READBACK_EN.
module lms_coeff_bank #(
  parameter int NB_I       = 18,
  parameter int FFE_LEN    = 21,
  parameter int NB         = 8,
  parameter int NBF        = 7,
  parameter int NB_DEC     = 4,
  parameter int CENTER_TAP = 10,
  parameter int NB_ADDR    = 5
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_valid,
  input  logic signed [NB_I-1:0]         i_sample,
  input  logic signed [FFE_LEN*NB-1:0]   i_new_coeff,
  input  logic [NB_DEC-1:0]              i_update_period,
  input  logic                           i_freeze,
  input  logic                           i_load,
  input  logic [NB_ADDR-1:0]             i_load_addr,
  input  logic signed [NB-1:0]           i_load_data,
  input  logic [NB_ADDR-1:0]             i_rd_addr,
  output logic signed [NB_I*FFE_LEN-1:0] o_xk_flat,
  output logic signed [FFE_LEN*NB-1:0]   o_coeff_flat,
  output logic                           o_update,
  output logic [15:0]                    o_update_count,
  output logic signed [NB-1:0]           o_rd_data
);

  localparam logic [NB_ADDR:0]        FFE_LEN_A   = (NB_ADDR+1)'(FFE_LEN);
  localparam logic signed [NB-1:0]    CENTER_INIT = NB'((1 << NBF) - 1);
  localparam logic signed [NB-1:0]    COEFF_ZERO  = {NB{1'b0}};
  localparam logic signed [NB_I-1:0]  SAMPLE_ZERO = {NB_I{1'b0}};
  localparam logic [NB_DEC-1:0]       CNT_ZERO    = {NB_DEC{1'b0}};

  logic signed [NB_I-1:0] xk_r    [FFE_LEN];
  logic signed [NB-1:0]   coeff_r [FFE_LEN];
  logic [NB_DEC-1:0]      cnt_r;
  logic                   update_r;
  logic [15:0]            update_count_r;
  logic signed [NB-1:0]   rd_data_r;

  logic load_ok_s;
  logic adapt_s;
  logic hit_s;

  // Qualify host writes and adapter write-back for this cycle.
  always_comb begin
    load_ok_s = i_load && ({1'b0, i_load_addr} < FFE_LEN_A);
    adapt_s   = i_valid && !i_freeze && !i_load;
    hit_s     = adapt_s && (cnt_r >= i_update_period);
  end

  // Tap delay line: oldest sample in slot 0, newest in slot FFE_LEN-1.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < FFE_LEN; k++) xk_r[k] <= SAMPLE_ZERO;
    end else if (i_valid) begin
      for (int k = 0; k < FFE_LEN - 1; k++) xk_r[k] <= xk_r[k+1];
      xk_r[FFE_LEN-1] <= i_sample;
    end
  end

  // Coefficient registers; a host load wins over the adapter result.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < FFE_LEN; k++)
        coeff_r[k] <= (k == CENTER_TAP) ? CENTER_INIT : COEFF_ZERO;
    end else begin
      for (int k = 0; k < FFE_LEN; k++) begin
        if (load_ok_s && (i_load_addr == NB_ADDR'(k)))
          coeff_r[k] <= i_load_data;
        else if (hit_s)
          coeff_r[k] <= i_new_coeff[k*NB +: NB];
      end
    end
  end

  // Decimation counter, update pulse and saturating update counter.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_r          <= CNT_ZERO;
      update_r       <= 1'b0;
      update_count_r <= 16'd0;
    end else if (i_load) begin
      cnt_r    <= CNT_ZERO;
      update_r <= 1'b0;
    end else if (adapt_s) begin
      if (hit_s) begin
        cnt_r    <= CNT_ZERO;
        update_r <= 1'b1;
        if (update_count_r != 16'hFFFF) update_count_r <= update_count_r + 16'd1;
      end else begin
        cnt_r    <= cnt_r + NB_DEC'(1);
        update_r <= 1'b0;
      end
    end else begin
      update_r <= 1'b0;
    end
  end

`ifdef LMS_COEFF_READBACK_EN
  logic signed [NB-1:0] rd_mux_s;

  // Readback mux; out-of-range addresses read as zero.
  always_comb begin
    rd_mux_s = COEFF_ZERO;
    for (int k = 0; k < FFE_LEN; k++) begin
      if (i_rd_addr == NB_ADDR'(k)) rd_mux_s = coeff_r[k];
    end
  end

  // Registered readback data.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) rd_data_r <= COEFF_ZERO;
    else          rd_data_r <= rd_mux_s;
  end
`else
  logic rd_addr_unused_s;
  assign rd_addr_unused_s = ^i_rd_addr;

  // Readback disabled: data stays at zero.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) rd_data_r <= COEFF_ZERO;
    else          rd_data_r <= COEFF_ZERO;
  end
`endif

  genvar g;
  generate
    for (g = 0; g < FFE_LEN; g++) begin : g_flat
      assign o_xk_flat[g*NB_I +: NB_I] = xk_r[g];
      assign o_coeff_flat[g*NB +: NB]  = coeff_r[g];
    end
  endgenerate

  assign o_update       = update_r;
  assign o_update_count = update_count_r;
  assign o_rd_data      = rd_data_r;

endmodule

// File: tb/tb_lms_coeff_bank.sv
// Directed self-checking bench for lms_coeff_bank with hand-computed expectations.
module tb_lms_coeff_bank;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_valid = 1'b0;
  logic [17:0]   i_sample = 18'd0;
  logic [167:0]  i_new_coeff = 168'd0;
  logic [3:0]    i_update_period = 4'd3;
  logic          i_freeze = 1'b0;
  logic          i_load = 1'b0;
  logic [4:0]    i_load_addr = 5'd0;
  logic [7:0]    i_load_data = 8'd0;
  logic [4:0]    i_rd_addr = 5'd30;
  logic [377:0]  o_xk_flat;
  logic [167:0]  o_coeff_flat;
  logic          o_update;
  logic [15:0]   o_update_count;
  logic [7:0]    o_rd_data;

  int errors = 0;
  int checks = 0;
  int pulses;
  int diffs;
  logic [7:0] pulse_vec;
  logic [7:0] tap10_after4;
  logic [7:0] rd_expect;

  lms_coeff_bank dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_sample(i_sample),
    .i_new_coeff(i_new_coeff), .i_update_period(i_update_period), .i_freeze(i_freeze),
    .i_load(i_load), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
    .i_rd_addr(i_rd_addr), .o_xk_flat(o_xk_flat), .o_coeff_flat(o_coeff_flat),
    .o_update(o_update), .o_update_count(o_update_count), .o_rd_data(o_rd_data)
  );

  always #5 i_clock = ~i_clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [7:0] tap(input int n);
    return o_coeff_flat[n*8 +: 8];
  endfunction

  function automatic logic [17:0] slot(input int n);
    return o_xk_flat[n*18 +: 18];
  endfunction

  initial begin
`ifdef LMS_COEFF_READBACK_EN
    rd_expect = 8'h7F;
`else
    rd_expect = 8'h00;
`endif
    // Reset state
    repeat (3) tick();
    check_val("rst_tap10", {24'd0, tap(10)}, 32'h7F);
    check_val("rst_tap0", {24'd0, tap(0)}, 32'h0);
    check_val("rst_tap20", {24'd0, tap(20)}, 32'h0);
    check_val("rst_slot0", {14'd0, slot(0)}, 32'h0);
    check_val("rst_count", {16'd0, o_update_count}, 32'h0);
    check_val("rst_update", {31'd0, o_update}, 32'h0);
    check_val("rst_rd", {24'd0, o_rd_data}, 32'h0);
    i_reset = 1'b1;
    tick();

    // Readback
    i_rd_addr = 5'd10;
    tick();
    check_val("rd_tap10", {24'd0, o_rd_data}, {24'd0, rd_expect});
    i_rd_addr = 5'd30;
    tick();
    check_val("rd_addr30", {24'd0, o_rd_data}, 32'h0);

    // Delay line under freeze
    i_freeze = 1'b1;
    i_update_period = 4'd0;
    for (int k = 0; k < 21; k++) i_new_coeff[k*8 +: 8] = 8'h55;
    pulses = 0;
    for (int i = 1; i <= 21; i++) begin
      i_valid = 1'b1;
      i_sample = 18'(i);
      tick();
      pulses += int'(o_update);
    end
    check_val("dl_slot20", {14'd0, slot(20)}, 32'd21);
    check_val("dl_slot0", {14'd0, slot(0)}, 32'd1);
    check_val("dl_slot10", {14'd0, slot(10)}, 32'd11);
    i_sample = 18'd22;
    tick();
    pulses += int'(o_update);
    check_val("dl22_slot0", {14'd0, slot(0)}, 32'd2);
    check_val("dl22_slot20", {14'd0, slot(20)}, 32'd22);
    i_sample = 18'h3FFFB;
    tick();
    pulses += int'(o_update);
    check_val("dl_neg", {14'd0, slot(20)}, 32'h3FFFB);
    check_val("dl_neg_prev", {14'd0, slot(19)}, 32'd22);
    i_valid = 1'b0;
    i_sample = 18'd99;
    tick();
    check_val("dl_hold", {14'd0, slot(20)}, 32'h3FFFB);
    check_val("frz_pulses", pulses, 32'd0);
    check_val("frz_tap10", {24'd0, tap(10)}, 32'h7F);
    check_val("frz_tap0", {24'd0, tap(0)}, 32'h0);
    check_val("frz_count", {16'd0, o_update_count}, 32'h0);

    // Decimation: period 3, 8 valids
    i_freeze = 1'b0;
    i_update_period = 4'd3;
    for (int k = 0; k < 21; k++) i_new_coeff[k*8 +: 8] = 8'h05;
    pulse_vec = 8'd0;
    tap10_after4 = 8'd0;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1;
      i_sample = 18'(100 + i);
      tick();
      pulse_vec[i] = o_update;
      if (i == 3) tap10_after4 = tap(10);
    end
    i_valid = 1'b0;
    check_val("dec_pulses", {24'd0, pulse_vec}, 32'h88);
    check_val("dec_tap10", {24'd0, tap10_after4}, 32'h05);
    check_val("dec_count", {16'd0, o_update_count}, 32'd2);
    tick();
    check_val("dec_pulse_low", {31'd0, o_update}, 32'h0);

    // Load priority at cnt == period
    for (int k = 0; k < 21; k++) i_new_coeff[k*8 +: 8] = 8'h09;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      tick();
      pulses += int'(o_update);
    end
    check_val("ld_pre_pulses", pulses, 32'd0);
    i_load = 1'b1;
    i_load_addr = 5'd3;
    i_load_data = 8'hF0;
    tick();
    check_val("ld_no_pulse", {31'd0, o_update}, 32'h0);
    check_val("ld_tap3", {24'd0, tap(3)}, 32'hF0);
    check_val("ld_tap4", {24'd0, tap(4)}, 32'h05);
    check_val("ld_count", {16'd0, o_update_count}, 32'd2);
    i_load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(o_update);
    end
    check_val("ld_cnt_cleared", pulses, 32'd0);
    check_val("ld_tap4_hold", {24'd0, tap(4)}, 32'h05);
    tick();
    check_val("ld_next_pulse", {31'd0, o_update}, 32'h1);
    check_val("ld_next_tap3", {24'd0, tap(3)}, 32'h09);
    check_val("ld_next_count", {16'd0, o_update_count}, 32'd3);
    i_valid = 1'b0;

    // Out-of-range load is ignored
    i_load = 1'b1;
    i_load_addr = 5'd25;
    i_load_data = 8'h33;
    tick();
    diffs = 0;
    for (int k = 0; k < 21; k++) if (tap(k) != 8'h09) diffs++;
    check_val("ld25_diffs", diffs, 32'd0);
    check_val("ld25_update", {31'd0, o_update}, 32'h0);
    i_load_addr = 5'd0;
    i_load_data = 8'h80;
    tick();
    i_load = 1'b0;
    check_val("ld0_tap0", {24'd0, tap(0)}, 32'h80);
    check_val("ld0_tap1", {24'd0, tap(1)}, 32'h09);

    // Reducing the period mid-count triggers on the next valid
    i_update_period = 4'd7;
    for (int k = 0; k < 21; k++) i_new_coeff[k*8 +: 8] = 8'(k * 3);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      tick();
      pulses += int'(o_update);
    end
    check_val("red_pre_pulses", pulses, 32'd0);
    i_update_period = 4'd1;
    tick();
    check_val("red_pulse", {31'd0, o_update}, 32'h1);
    check_val("red_tap0", {24'd0, tap(0)}, 32'd0);
    check_val("red_tap5", {24'd0, tap(5)}, 32'd15);
    check_val("red_tap20", {24'd0, tap(20)}, 32'd60);
    check_val("red_count", {16'd0, o_update_count}, 32'd4);

    // Period 0: update every valid
    i_update_period = 4'd0;
    for (int k = 0; k < 21; k++) i_new_coeff[k*8 +: 8] = 8'(k + 100);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(o_update);
    end
    check_val("p0_pulses", pulses, 32'd3);
    check_val("p0_count", {16'd0, o_update_count}, 32'd7);
    check_val("p0_tap20", {24'd0, tap(20)}, 32'h78);

    // Asynchronous reset mid-operation
    i_load = 1'b1;
    i_load_addr = 5'd10;
    i_load_data = 8'h11;
    i_sample = 18'd7;
    @(posedge i_clock);
    #3;
    i_reset = 1'b0;
    #1;
    check_val("arst_tap10", {24'd0, tap(10)}, 32'h7F);
    check_val("arst_tap20", {24'd0, tap(20)}, 32'h0);
    check_val("arst_slot20", {14'd0, slot(20)}, 32'h0);
    check_val("arst_count", {16'd0, o_update_count}, 32'h0);
    check_val("arst_update", {31'd0, o_update}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lms_coeff_bank.md
# lms_coeff_bank

Register bank and tap delay line on the supply side of the LMS adapter. It holds the FFE input window and the FFE coefficients, and presents both flat to the FFE and to the adapter. On a programmable decimation schedule it latches the adapter's combinational `o_new_coeff` result back into the coefficient registers, closing the LMS loop. It also provides host load, freeze and an optional readback port.

## Interface
Parameters:
- `NB_I`, 18, sample width (`x[k]`)
- `FFE_LEN`, 21, number of taps
- `NB`, 8, coefficient width
- `NBF`, 7, coefficient fractional bits
- `NB_DEC`, 4, update-period counter width
- `CENTER_TAP`, 10, tap index initialised to ~1.0
- `NB_ADDR`, 5, tap address width; must satisfy 2^`NB_ADDR` ≥ `FFE_LEN`

Ports:
- `i_clock` in 1: single clock, rising edge.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: one new sample this cycle.
- `i_sample` in `NB_I` signed: new FFE input sample.
- `i_new_coeff` in `FFE_LEN*NB` signed: updated coefficients from the LMS adapter.
- `i_update_period` in `NB_DEC`: update once every `i_update_period`+1 valid samples.
- `i_freeze` in 1: suppress adaptation.
- `i_load` in 1: host coefficient write strobe.
- `i_load_addr` in `NB_ADDR`: tap to write.
- `i_load_data` in `NB` signed: value to write.
- `i_rd_addr` in `NB_ADDR`: readback tap address.
- `o_xk_flat` out `NB_I*FFE_LEN` signed: sample window; slot `FFE_LEN-1` is newest, slot 0 is oldest.
- `o_coeff_flat` out `FFE_LEN*NB` signed: current coefficients, same indexing.
- `o_update` out 1: one-cycle pulse when coefficients were latched from the adapter.
- `o_update_count` out 16: saturating count of adapter updates.
- `o_rd_data` out `NB` signed: readback data.

## Operation
- **Reset values (async, `i_reset`=0):**
  - all `xk` = 0
  - all coefficients = 0, except tap `CENTER_TAP` = 2^`NBF`−1 (0x7F for `NB`=8)
  - decimation counter `cnt` = 0
  - `o_update` = 0, `o_update_count` = 0, `o_rd_data` = 0
- **Delay line:** on `i_valid`:
  - `xk[k]` ← `xk[k+1]` for k < `FFE_LEN`−1
  - `xk[FFE_LEN-1]` ← `i_sample`
  - Without `i_valid`, the window holds.
- **Adaptation:** `i_new_coeff` is computed combinationally by the adapter from the pre-shift `o_xk_flat`/`o_coeff_flat`. The bank samples it in the same cycle as `i_valid`.
- **Decimation:** evaluated only on cycles with `i_valid`=1, `i_freeze`=0 and `i_load`=0.
  - If `cnt` ≥ `i_update_period`: coefficients ← `i_new_coeff`, `cnt` ← 0, `o_update` = 1 the next cycle, `o_update_count` += 1 (saturates at 0xFFFF).
  - Otherwise `cnt` += 1.
  - The ≥ comparison ensures that reducing `i_update_period` mid-count triggers the update on the next valid sample, with no wrap-around.
- **Freeze:** `cnt` and the coefficients hold. The delay line keeps shifting.
- **Host load** has priority over adaptation in the same cycle:
  - If `i_load_addr` < `FFE_LEN`: `w[i_load_addr]` ← `i_load_data`.
  - Addresses ≥ `FFE_LEN` are ignored; no register changes.
  - In either case `cnt` ← 0, and no adapter update or `o_update` pulse occurs that cycle.
- **Width rules:** coefficients are stored verbatim. Saturation and rounding are the adapter's responsibility.

## Timing
- `o_xk_flat`, `o_coeff_flat` and `o_update` are registered; they change one cycle after the qualifying edge.
- Latency from `i_valid` to the new window and new coefficients is 1 cycle.
- A back-to-back `i_valid` every cycle is supported. With `i_update_period`=0, coefficients update on every sample.
- `o_update` is high for exactly one cycle per update, never on a load cycle.
- Reset asserted mid-operation immediately forces all reset values, regardless of `i_valid` or `i_load`.

## Configuration
- **`LMS_COEFF_READBACK_EN` defined:** `o_rd_data` is registered `w[i_rd_addr]` with 1-cycle latency. It returns 0 for `i_rd_addr` ≥ `FFE_LEN`.
- **Not defined:** the `i_rd_addr` input is ignored and `o_rd_data` is constant 0. The port list is unchanged.

## Test plan
- **Reset and center tap:** release `i_reset` → `o_coeff_flat` has tap 10 = 0x7F, all other taps 0, `o_xk_flat` = 0, `o_update_count` = 0.
- **Delay line:** drive 21 valid samples 1..21 → slot 20 = 21, slot 0 = 1. The 22nd sample (22) shifts out value 1.
- **Decimation:** `i_update_period`=3, `i_new_coeff` all 0x05, 8 consecutive valids → exactly 2 `o_update` pulses, after the 4th and 8th valid; coefficients = 0x05 after the 4th; count = 2.
- **Freeze and load priority:**
  - `i_freeze`=1 for 10 valids → no pulses, coefficients unchanged.
  - `i_load` addr 3 data 0xF0 together with `i_valid` at `cnt`=period → `w[3]`=0xF0, no pulse, `cnt`=0.
  - `i_load_addr`=25 → no register change.
- **Readback (`LMS_COEFF_READBACK_EN`):** after reset, `i_rd_addr`=10 → `o_rd_data`=0x7F one cycle later; `i_rd_addr`=30 → 0. With the macro undefined, `o_rd_data` = 0 always.
